// File: rtl/mlsu_req_sched.sv
// Request scheduler in front of the MLSU pe_req port: round-robin between the vector and
// matrix issue paths, one-entry output register, direction phases and outstanding counters.
module mlsu_req_sched #(
  parameter int PayloadW = 128,
  parameter int MaxOutst = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [1:0]                        req_valid_i,
  output logic [1:0]                        req_ready_o,
  input  logic [1:0]                        req_is_load_i,
  input  logic [1:0][PayloadW-1:0]          req_payload_i,
  output logic                              mlsu_valid_o,
  input  logic                              mlsu_ready_i,
  output logic [PayloadW-1:0]               mlsu_payload_o,
  output logic                              mlsu_is_load_o,
  output logic                              mlsu_src_o,
  input  logic                              ld_done_i,
  input  logic                              st_done_i,
  output logic [$clog2(MaxOutst+1)-1:0]     ld_outst_o,
  output logic [$clog2(MaxOutst+1)-1:0]     st_outst_o,
  output logic                              busy_o,
  output logic                              err_o
);

  localparam int CntW = $clog2(MaxOutst + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutst);

  typedef enum logic [1:0] {
    IDLE,
    LD,
    ST,
    DRAIN
  } state_t;

  state_t state;
  logic   drain_is_load;
  logic   rr;
  logic   rst_q;

  logic   has_win;
  logic   win;
  logic   win_load;
  logic   or_free;
  logic   cnt_room;
  logic   dir_ok;
  logic   accept;
  logic   ld_inc;
  logic   st_inc;
  logic   ld_dec;
  logic   st_dec;
  logic   ld_zero;
  logic   st_zero;
  logic   opposite;
  logic [CntW-1:0] ld_next;
  logic [CntW-1:0] st_next;

  assign ld_zero = (ld_outst_o == '0);
  assign st_zero = (st_outst_o == '0);

  assign has_win  = |req_valid_i;
  assign win      = req_valid_i[rr] ? rr : ~rr;
  assign win_load = req_is_load_i[win];
  assign or_free  = !mlsu_valid_o || mlsu_ready_i;
  assign cnt_room = win_load ? (ld_outst_o < MaxCnt) : (st_outst_o < MaxCnt);
  assign dir_ok   = (state == IDLE) ||
                    ((state == LD) && win_load) ||
                    ((state == ST) && !win_load);
  assign opposite = ((state == LD) && !win_load) || ((state == ST) && win_load);

  // Grants are held off during reset and for the first cycle after it.
  assign accept = has_win && or_free && cnt_room && dir_ok && !rst_q && !rst_i;

  assign req_ready_o = accept ? (win ? 2'b10 : 2'b01) : 2'b00;

  assign ld_inc = accept && win_load;
  assign st_inc = accept && !win_load;
  assign ld_dec = ld_done_i && !ld_zero;
  assign st_dec = st_done_i && !st_zero;

  always_comb begin
    ld_next = ld_outst_o;
    if (ld_inc && !ld_dec) begin
      ld_next = ld_outst_o + CntW'(1);
    end else if (!ld_inc && ld_dec) begin
      ld_next = ld_outst_o - CntW'(1);
    end
  end

  always_comb begin
    st_next = st_outst_o;
    if (st_inc && !st_dec) begin
      st_next = st_outst_o + CntW'(1);
    end else if (!st_inc && st_dec) begin
      st_next = st_outst_o - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    rst_q <= rst_i;
  end

  // A done pulse against an empty counter is a protocol violation; the flag stays set until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ld_outst_o <= '0;
      st_outst_o <= '0;
      err_o      <= 1'b0;
    end else begin
      ld_outst_o <= ld_next;
      st_outst_o <= st_next;
      if ((ld_done_i && ld_zero) || (st_done_i && st_zero)) begin
        err_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mlsu_valid_o   <= 1'b0;
      mlsu_payload_o <= '0;
      mlsu_is_load_o <= 1'b0;
      mlsu_src_o     <= 1'b0;
      rr             <= 1'b0;
    end else begin
      if (accept) begin
        mlsu_valid_o   <= 1'b1;
        mlsu_payload_o <= req_payload_i[win];
        mlsu_is_load_o <= win_load;
        mlsu_src_o     <= win;
        rr             <= ~win;
      end else if (mlsu_ready_i) begin
        mlsu_valid_o <= 1'b0;
      end
    end
  end

  // An opposite-direction winner parks the scheduler in DRAIN; nothing is granted
  // until the old phase has fully completed and the output register is empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      drain_is_load <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= win_load ? LD : ST;
          end
        end
        LD, ST: begin
          if (has_win && opposite) begin
            state         <= DRAIN;
            drain_is_load <= (state == LD);
          end else if (!accept && !mlsu_valid_o &&
                       ((state == LD) ? ld_zero : st_zero)) begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (!mlsu_valid_o && (drain_is_load ? ld_zero : st_zero)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = !ld_zero || !st_zero || mlsu_valid_o;

endmodule
